r_channel: RTL and testbench
============================

// Module: r_channel
// PURPOSE
//  OBI R-channel response stage; sits downstream of the cache controller, in parallel with the A-channel stage.
//  Buffers controller completions {err, rdata} in a small FIFO and presents them to the OBI master via rvalid/rready.
//  Tracks accepted-but-unanswered requests and drives internal_gnt, which throttles A-channel acceptance.
// PARAMETERS
//  DATA_WIDTH       32  width of read data returned to master
//  FIFO_DEPTH       2   response buffer entries (>=1)
//  MAX_OUTSTANDING  2   max accepted requests without a completed R handshake (>=1)
// PORTS
//  clk              in   1           clock, all state on rising edge
//  rst_n            in   1           async active-low reset
//  a_fire           in   1           A-channel accept this cycle (obi_req.req && internal_gnt)
//  internal_gnt     out  1           1 = A-channel may accept a new request
//  ctrl_valid       in   1           controller offers a completion
//  ctrl_ready       out  1           block can take the completion
//  ctrl_rdata       in   DATA_WIDTH  read data (controller drives '0 for writes)
//  ctrl_err         in   1           operation failed (miss / illegal address)
//  obi_rvalid       out  1           response valid to master
//  obi_rready       in   1           master accepts response
//  obi_rdata        out  DATA_WIDTH  response data
//  obi_err          out  1           response error flag
//  spurious_rsp     out  1           sticky: completion arrived with nothing outstanding
// BEHAVIOUR
//  Reset values (async, immediate):
//   - Counters and FIFO pointers 0 -> obi_rvalid=0, obi_rdata='0, obi_err=0, spurious_rsp=0.
//   - ctrl_ready=1, internal_gnt=1.
//  Reset mid-operation discards all buffered responses and outstanding counts; no response is replayed.
//  Outstanding counter out_cnt, width $clog2(MAX_OUTSTANDING+1):
//   - +1 on a_fire; -1 on r_fire = obi_rvalid && obi_rready; both in same cycle -> unchanged.
//   - internal_gnt = (out_cnt < MAX_OUTSTANDING), from registered count only; no same-cycle bypass of r_fire.
//   - a_fire while internal_gnt=0 is a caller violation: counter saturates at MAX_OUTSTANDING, never wraps.
//  Response FIFO (circular, rd/wr pointers wrap at FIFO_DEPTH, count 0..FIFO_DEPTH):
//   - ctrl_ready = !full; push = ctrl_valid && ctrl_ready; entry = {ctrl_err, ctrl_rdata}.
//   - obi_rvalid = !empty; obi_rdata/obi_err = head entry; pop on r_fire.
//   - Latency: push into empty FIFO -> obi_rvalid high the next cycle; no combinational ctrl->obi path.
//   - Push and pop in the same cycle: count unchanged, both pointers advance; allowed whenever not full.
//   - Full: ctrl_ready=0 even if r_fire occurs in that cycle (no pass-through); controller holds ctrl_valid/data.
//   - obi_rvalid, once high, stays high with stable rdata/err until r_fire (OBI rule).
//  Spurious completion: push attempted while out_cnt == fifo_count (every outstanding request already answered):
//   - Entry is dropped; ctrl_ready still acknowledges it.
//   - spurious_rsp set, sticky until reset.
//  Order: responses are returned strictly in completion order, which matches request order (in-order controller).
// TESTING
//  1. Reset -> internal_gnt=1, ctrl_ready=1, obi_rvalid=0, obi_rdata=0, spurious_rsp=0.
//  2. a_fire, then ctrl_valid with rdata=0xDEADBEEF, err=0 and rready=1
//     -> rvalid=1 with 0xDEADBEEF next cycle; one-cycle pulse; out_cnt returns to 0.
//  3. 2x a_fire -> internal_gnt=0.
//     Two completions (0x11, 0x22 err=1) with rready=0 -> FIFO full, ctrl_ready=0.
//     Set rready -> 0x11/err0 then 0x22/err1; internal_gnt=1 after first pop.
//  4. rready toggles 1/0 every cycle while completions stream back-to-back
//     -> no loss, no reorder, rdata stable while rvalid && !rready.
//  5. ctrl_valid with no a_fire ever -> ctrl_ready=1, rvalid stays 0, spurious_rsp=1 until rst_n low.
//  6. rst_n low with two buffered responses -> rvalid=0 immediately, internal_gnt=1; no stale data after release.

Source files
------------

// File: rtl/r_channel.sv
// OBI R-channel response stage: buffers controller completions in a small circular FIFO,
// returns them to the master over rvalid/rready and throttles A-channel acceptance via internal_gnt.
module r_channel #(
    parameter int DATA_WIDTH      = 32,
    parameter int FIFO_DEPTH      = 2,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    // A-channel side
    input  logic                  a_fire,
    output logic                  internal_gnt,
    // controller completion side
    input  logic                  ctrl_valid,
    output logic                  ctrl_ready,
    input  logic [DATA_WIDTH-1:0] ctrl_rdata,
    input  logic                  ctrl_err,
    // OBI R channel
    output logic                  obi_rvalid,
    input  logic                  obi_rready,
    output logic [DATA_WIDTH-1:0] obi_rdata,
    output logic                  obi_err,
    // status
    output logic                  spurious_rsp
);

    // Handshakes: a transfer happens on a rising edge where valid && ready are both high.
    // obi_rvalid never drops and the head entry never changes until that transfer.

    localparam int OCW  = $clog2(MAX_OUTSTANDING + 1);
    localparam int FCW  = $clog2(FIFO_DEPTH + 1);
    localparam int PW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int EW   = DATA_WIDTH + 1;
    localparam int CMPW = (OCW > FCW) ? OCW : FCW;

    logic [OCW-1:0] out_cnt_q,  out_cnt_d;
    logic [FCW-1:0] fifo_cnt_q, fifo_cnt_d;
    logic [PW-1:0]  wr_ptr_q,   wr_ptr_d;
    logic [PW-1:0]  rd_ptr_q,   rd_ptr_d;
    logic           spurious_q, spurious_d;
    logic [EW-1:0]  mem_q [FIFO_DEPTH];

    logic full;
    logic empty;
    logic r_fire;
    logic push_req;
    logic nothing_pending;
    logic push;
    logic pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == PW'(FIFO_DEPTH - 1)) begin
            return '0;
        end
        return p + PW'(1);
    endfunction

    // Status and output decode, all from registered state (no ctrl->obi combinational path).
    always_comb begin
        full            = (fifo_cnt_q == FCW'(FIFO_DEPTH));
        empty           = (fifo_cnt_q == '0);
        ctrl_ready      = !full;
        internal_gnt    = (out_cnt_q < OCW'(MAX_OUTSTANDING));
        obi_rvalid      = !empty;
        {obi_err, obi_rdata} = mem_q[rd_ptr_q];
        spurious_rsp    = spurious_q;
        r_fire          = obi_rvalid && obi_rready;
        push_req        = ctrl_valid && ctrl_ready;
        // Every outstanding request already has its answer buffered: a new completion is bogus.
        nothing_pending = (CMPW'(out_cnt_q) == CMPW'(fifo_cnt_q));
        push            = push_req && !nothing_pending;
        pop             = r_fire;
    end

    always_comb begin
        out_cnt_d  = out_cnt_q;
        fifo_cnt_d = fifo_cnt_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        spurious_d = spurious_q;

        unique case ({a_fire, r_fire})
            2'b10: begin
                if (out_cnt_q != OCW'(MAX_OUTSTANDING)) begin
                    out_cnt_d = out_cnt_q + OCW'(1);
                end
            end
            2'b01: begin
                if (out_cnt_q != '0) begin
                    out_cnt_d = out_cnt_q - OCW'(1);
                end
            end
            default: ;
        endcase

        unique case ({push, pop})
            2'b10:   fifo_cnt_d = fifo_cnt_q + FCW'(1);
            2'b01:   fifo_cnt_d = fifo_cnt_q - FCW'(1);
            default: ;
        endcase

        if (push) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        if (push_req && nothing_pending) begin
            spurious_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_cnt_q  <= '0;
            fifo_cnt_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            spurious_q <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            out_cnt_q  <= out_cnt_d;
            fifo_cnt_q <= fifo_cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            spurious_q <= spurious_d;
            if (push) begin
                mem_q[wr_ptr_q] <= {ctrl_err, ctrl_rdata};
            end
        end
    end

endmodule

// File: tb/tb_r_channel.sv
// Directed bench for r_channel: scoreboard queue of expected {err, rdata} responses,
// checked whenever the R channel hands a response to the master.
module tb_r_channel;

    localparam int DW = 32;
    localparam int N_STREAM = 8;

    logic          clk;
    logic          rst_n;
    logic          a_fire;
    logic          internal_gnt;
    logic          ctrl_valid;
    logic          ctrl_ready;
    logic [DW-1:0] ctrl_rdata;
    logic          ctrl_err;
    logic          obi_rvalid;
    logic          obi_rready;
    logic [DW-1:0] obi_rdata;
    logic          obi_err;
    logic          spurious_rsp;

    logic [DW:0] exp_q[$];
    logic [DW:0] exp_item;
    logic [DW:0] hold_data;
    logic        hold_valid;
    int          n_vec;
    int          n_err;
    int          rx_cnt;

    r_channel #(
        .DATA_WIDTH      (DW),
        .FIFO_DEPTH      (2),
        .MAX_OUTSTANDING (2)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .a_fire       (a_fire),
        .internal_gnt (internal_gnt),
        .ctrl_valid   (ctrl_valid),
        .ctrl_ready   (ctrl_ready),
        .ctrl_rdata   (ctrl_rdata),
        .ctrl_err     (ctrl_err),
        .obi_rvalid   (obi_rvalid),
        .obi_rready   (obi_rready),
        .obi_rdata    (obi_rdata),
        .obi_err      (obi_err),
        .spurious_rsp (spurious_rsp)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: response check on the falling edge, then return just after the rising edge.
    task automatic tick();
        @(negedge clk);
        if (rst_n) begin
            if (hold_valid) begin
                chk("hold_rvalid", 64'(obi_rvalid), 64'd1);
                chk("hold_data", 64'({obi_err, obi_rdata}), 64'(hold_data));
            end
            if (obi_rvalid && obi_rready) begin
                chk("rsp_expected", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    exp_item = exp_q.pop_front();
                    chk("rsp_data", 64'({obi_err, obi_rdata}), 64'(exp_item));
                end
                rx_cnt++;
            end
            hold_valid = obi_rvalid && !obi_rready;
            hold_data  = {obi_err, obi_rdata};
        end else begin
            hold_valid = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    // driver: offer one completion and hold it until accepted (bounded)
    task automatic complete(input logic [DW-1:0] data, input logic err);
        int budget;
        ctrl_valid = 1'b1;
        ctrl_rdata = data;
        ctrl_err   = err;
        budget     = 50;
        while (!ctrl_ready && budget > 0) begin
            tick();
            budget--;
        end
        chk("complete_accept", 64'(ctrl_ready), 64'd1);
        exp_q.push_back({err, data});
        tick();
        ctrl_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        hold_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        logic [DW-1:0] cur_d;
        logic          cur_e;
        logic          acc;
        int            issued;
        int            pushed;

        n_vec      = 0;
        n_err      = 0;
        rx_cnt     = 0;
        hold_valid = 1'b0;
        hold_data  = '0;
        rst_n      = 1'b0;
        a_fire     = 1'b0;
        ctrl_valid = 1'b0;
        ctrl_rdata = '0;
        ctrl_err   = 1'b0;
        obi_rready = 1'b0;

        // 1. reset values
        tick();
        tick();
        chk("rst_gnt", 64'(internal_gnt), 64'd1);
        chk("rst_ctrl_ready", 64'(ctrl_ready), 64'd1);
        chk("rst_rvalid", 64'(obi_rvalid), 64'd0);
        chk("rst_rdata", 64'(obi_rdata), 64'd0);
        chk("rst_err", 64'(obi_err), 64'd0);
        chk("rst_spurious", 64'(spurious_rsp), 64'd0);
        rst_n = 1'b1;
        tick();

        // 2. single request/response, one-cycle latency and one-cycle pulse
        a_fire = 1'b1;
        tick();
        a_fire     = 1'b0;
        obi_rready = 1'b1;
        ctrl_valid = 1'b1;
        ctrl_rdata = 32'hDEADBEEF;
        ctrl_err   = 1'b0;
        chk("t2_ctrl_ready", 64'(ctrl_ready), 64'd1);
        chk("t2_rvalid_before", 64'(obi_rvalid), 64'd0);
        exp_q.push_back({1'b0, 32'hDEADBEEF});
        tick();
        ctrl_valid = 1'b0;
        chk("t2_rvalid", 64'(obi_rvalid), 64'd1);
        chk("t2_rdata", 64'(obi_rdata), 64'hDEADBEEF);
        tick();
        chk("t2_rvalid_pulse", 64'(obi_rvalid), 64'd0);

        // 3. fill to MAX_OUTSTANDING and FIFO_DEPTH, then drain
        obi_rready = 1'b0;
        a_fire = 1'b1;
        tick();
        chk("t3_gnt_one", 64'(internal_gnt), 64'd1);
        tick();
        a_fire = 1'b0;
        chk("t3_gnt_full", 64'(internal_gnt), 64'd0);
        complete(32'h11, 1'b0);
        complete(32'h22, 1'b1);
        chk("t3_ctrl_ready_full", 64'(ctrl_ready), 64'd0);
        chk("t3_rvalid", 64'(obi_rvalid), 64'd1);
        chk("t3_head", 64'({obi_err, obi_rdata}), 64'({1'b0, 32'h11}));
        obi_rready = 1'b1;
        chk("t3_no_passthru", 64'(ctrl_ready), 64'd0);
        chk("t3_no_gnt_bypass", 64'(internal_gnt), 64'd0);
        tick();
        chk("t3_gnt_after_pop", 64'(internal_gnt), 64'd1);
        chk("t3_ctrl_ready_after_pop", 64'(ctrl_ready), 64'd1);
        chk("t3_head2", 64'({obi_err, obi_rdata}), 64'({1'b1, 32'h22}));
        tick();
        chk("t3_drained", 64'(obi_rvalid), 64'd0);
        obi_rready = 1'b0;

        // 4. streaming completions with rready toggling every cycle
        issued = 0;
        pushed = 0;
        rx_cnt = 0;
        cur_d  = $urandom;
        cur_e  = 1'($urandom_range(0, 1));
        for (int cyc = 0; cyc < 300 && rx_cnt < N_STREAM; cyc++) begin
            a_fire     = (issued < N_STREAM) && internal_gnt;
            ctrl_valid = (pushed < issued);
            ctrl_rdata = cur_d;
            ctrl_err   = cur_e;
            obi_rready = (cyc % 2) == 1;
            acc        = ctrl_valid && ctrl_ready;
            if (acc) begin
                exp_q.push_back({cur_e, cur_d});
            end
            tick();
            if (a_fire) begin
                issued++;
            end
            if (acc) begin
                pushed++;
                cur_d = $urandom;
                cur_e = 1'($urandom_range(0, 1));
            end
        end
        a_fire     = 1'b0;
        ctrl_valid = 1'b0;
        obi_rready = 1'b0;
        chk("t4_rx_count", 64'(rx_cnt), 64'(N_STREAM));
        chk("t4_queue_empty", 64'(exp_q.size()), 64'd0);
        chk("t4_no_spurious", 64'(spurious_rsp), 64'd0);

        // 5. completion with nothing outstanding is dropped and flagged
        do_reset();
        ctrl_valid = 1'b1;
        ctrl_rdata = 32'h55;
        ctrl_err   = 1'b0;
        chk("t5_ctrl_ready", 64'(ctrl_ready), 64'd1);
        tick();
        ctrl_valid = 1'b0;
        chk("t5_spurious", 64'(spurious_rsp), 64'd1);
        chk("t5_rvalid", 64'(obi_rvalid), 64'd0);
        tick();
        tick();
        tick();
        chk("t5_spurious_sticky", 64'(spurious_rsp), 64'd1);
        chk("t5_rvalid_stays", 64'(obi_rvalid), 64'd0);
        rst_n = 1'b0;
        #1;
        chk("t5_spurious_cleared", 64'(spurious_rsp), 64'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // 6. asynchronous reset with two buffered responses
        a_fire = 1'b1;
        tick();
        tick();
        a_fire = 1'b0;
        complete(32'hA1, 1'b0);
        complete(32'hA2, 1'b1);
        chk("t6_rvalid_before", 64'(obi_rvalid), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rvalid_async", 64'(obi_rvalid), 64'd0);
        chk("t6_gnt_async", 64'(internal_gnt), 64'd1);
        chk("t6_ctrl_ready_async", 64'(ctrl_ready), 64'd1);
        chk("t6_rdata_async", 64'(obi_rdata), 64'd0);
        exp_q.delete();
        hold_valid = 1'b0;
        tick();
        rst_n      = 1'b1;
        obi_rready = 1'b1;
        tick();
        tick();
        tick();
        chk("t6_no_stale", 64'(obi_rvalid), 64'd0);
        obi_rready = 1'b0;

        // 7. a_fire while throttled saturates the outstanding count
        a_fire = 1'b1;
        tick();
        tick();
        tick();
        a_fire = 1'b0;
        chk("t7_gnt_sat", 64'(internal_gnt), 64'd0);
        complete(32'h77, 1'b0);
        chk("t7_rvalid", 64'(obi_rvalid), 64'd1);
        obi_rready = 1'b1;
        tick();
        obi_rready = 1'b0;
        chk("t7_gnt_after_pop", 64'(internal_gnt), 64'd1);
        chk("t7_queue_empty", 64'(exp_q.size()), 64'd0);
        chk("t7_no_spurious", 64'(spurious_rsp), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
